// File: rtl/tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// tx_framer_pkg
// Shared types and helpers for the TX symbol framer.
//   state_t    : framer FSM states (CRC is only reachable with TX_FRAMER_CRC_EN)
//   dibit_t    : one I/Q symbol, bit 1 = I, bit 0 = Q
//   CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_byte  : CRC-8 update over one byte, MSB first, no reflection
//   byte_dibit : symbol idx (0..3) of a byte, MSB pair first
// -----------------------------------------------------------------------------
package tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        PAYLOAD  = 3'd3,
        CRC      = 3'd4
    } state_t;

    typedef logic [1:0] dibit_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic dibit_t byte_dibit(input logic [7:0] data, input logic [1:0] idx);
        logic [7:0] sh;
        sh = data << {idx, 1'b0};
        return sh[7:6];
    endfunction

endpackage

// File: rtl/tx_crc8.sv
// -----------------------------------------------------------------------------
// tx_crc8
// Byte-wise CRC-8 accumulator (poly 0x07, init 0x00, MSB first).
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0x00 (start of frame)
//   en       : fold data into the running CRC this cycle
//   data     : byte to fold in
//   crc      : current CRC value (registered)
// -----------------------------------------------------------------------------
module tx_crc8
    import tx_framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // CRC register: clear wins over update.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= 8'h00;
        end else if (clr) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/tx_symbol_framer.sv
// -----------------------------------------------------------------------------
// tx_symbol_framer
// Serialises an AXI-Stream byte stream into I/Q dibits, framing each packet
// as preamble, sync word, payload (and CRC-8 when TX_FRAMER_CRC_EN is defined).
//   clk, rst            : clock, synchronous active-high reset
//   in_data/valid/last  : AXIS byte input; in_ready accepts a byte
//   out_I/out_Q/valid   : registered symbol output; advances on out_ready
//   busy                : high whenever the framer is not IDLE
// Optional: `define TX_FRAMER_CRC_EN appends a 4-symbol CRC-8 after payload.
// -----------------------------------------------------------------------------
module tx_symbol_framer
    import tx_framer_pkg::*;
#(
    parameter int                   PREAMBLE_LEN = 16,
    parameter int                   SYNC_BITS    = 16,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD    = 16'hD391
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_I,
    output logic       out_Q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int SYNC_SYMS = SYNC_BITS / 2;
    localparam int CNT_MAX0  = (PREAMBLE_LEN > SYNC_SYMS) ? PREAMBLE_LEN : SYNC_SYMS;
    localparam int CNT_MAX   = (CNT_MAX0 > 4) ? CNT_MAX0 : 4;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_SYMS - 1);

    // cnt_r indexes the symbol currently presented within the current state.
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [7:0]       byte_r, byte_nxt_s;
    logic             byte_full_r, byte_full_nxt_s;
    logic             byte_last_r, byte_last_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    dibit_t           out_iq_r, out_iq_nxt_s;
    logic             busy_r;
    logic             fire_s, take_s, in_ready_s;
    logic [SYNC_BITS-1:0] sync_sh_s;

`ifdef TX_FRAMER_CRC_EN
    logic [7:0] crc_s;
    logic       crc_clr_s;

    tx_crc8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_clr_s),
        .en   (take_s),
        .data (in_data),
        .crc  (crc_s)
    );
`endif

    assign fire_s    = out_valid_r & out_ready;
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign sync_sh_s = SYNC_WORD << {cnt_inc_s, 1'b0};

    // A new byte is taken when the holding register is empty, or when its
    // final symbol leaves this cycle and it is not the packet's last byte.
    assign in_ready_s = (state_r == PAYLOAD) &&
                        (!byte_full_r || (fire_s && (cnt_r[1:0] == 2'd3) && !byte_last_r));
    assign take_s     = in_valid & in_ready_s;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        byte_nxt_s      = byte_r;
        byte_full_nxt_s = byte_full_r;
        byte_last_nxt_s = byte_last_r;
        out_valid_nxt_s = out_valid_r;
        out_iq_nxt_s    = out_iq_r;
`ifdef TX_FRAMER_CRC_EN
        crc_clr_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                // The pending byte only triggers the frame; it is taken in PAYLOAD.
                if (in_valid) begin
                    state_nxt_s     = PREAMBLE;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    out_iq_nxt_s    = 2'b11;
                    out_valid_nxt_s = 1'b1;
`ifdef TX_FRAMER_CRC_EN
                    crc_clr_s       = 1'b1;
`endif
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            PREAMBLE: begin
                if (fire_s && (cnt_r == PRE_LAST)) begin
                    state_nxt_s  = SYNC;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    out_iq_nxt_s = SYNC_WORD[SYNC_BITS-1 -: 2];
                end else if (fire_s) begin
                    cnt_nxt_s    = cnt_inc_s;
                    out_iq_nxt_s = {~cnt_inc_s[0], ~cnt_inc_s[0]};
                end else begin
                    cnt_nxt_s    = cnt_r;
                end
            end
            SYNC: begin
                if (fire_s && (cnt_r == SYNC_LAST)) begin
                    state_nxt_s     = PAYLOAD;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    out_valid_nxt_s = 1'b0;
                end else if (fire_s) begin
                    cnt_nxt_s    = cnt_inc_s;
                    out_iq_nxt_s = sync_sh_s[SYNC_BITS-1 -: 2];
                end else begin
                    cnt_nxt_s    = cnt_r;
                end
            end
            PAYLOAD: begin
                if (take_s) begin
                    byte_nxt_s      = in_data;
                    byte_full_nxt_s = 1'b1;
                    byte_last_nxt_s = in_last;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    out_iq_nxt_s    = in_data[7:6];
                    out_valid_nxt_s = 1'b1;
                end else if (fire_s && (cnt_r[1:0] != 2'd3)) begin
                    cnt_nxt_s    = cnt_inc_s;
                    out_iq_nxt_s = byte_dibit(byte_r, cnt_inc_s[1:0]);
                end else if (fire_s && byte_last_r) begin
                    byte_full_nxt_s = 1'b0;
                    byte_last_nxt_s = 1'b0;
                    cnt_nxt_s       = {CNT_W{1'b0}};
`ifdef TX_FRAMER_CRC_EN
                    // Reuse the byte register to shift out the finished CRC.
                    state_nxt_s     = CRC;
                    byte_nxt_s      = crc_s;
                    out_iq_nxt_s    = crc_s[7:6];
                    out_valid_nxt_s = 1'b1;
`else
                    state_nxt_s     = IDLE;
                    out_iq_nxt_s    = 2'b00;
                    out_valid_nxt_s = 1'b0;
`endif
                end else if (fire_s) begin
                    // Byte exhausted and no replacement offered: bubble.
                    byte_full_nxt_s = 1'b0;
                    out_valid_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
`ifdef TX_FRAMER_CRC_EN
            CRC: begin
                if (fire_s && (cnt_r[1:0] == 2'd3)) begin
                    state_nxt_s     = IDLE;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    out_iq_nxt_s    = 2'b00;
                    out_valid_nxt_s = 1'b0;
                end else if (fire_s) begin
                    cnt_nxt_s    = cnt_inc_s;
                    out_iq_nxt_s = byte_dibit(byte_r, cnt_inc_s[1:0]);
                end else begin
                    cnt_nxt_s    = cnt_r;
                end
            end
`endif
            default: begin
                state_nxt_s     = IDLE;
                cnt_nxt_s       = {CNT_W{1'b0}};
                byte_full_nxt_s = 1'b0;
                byte_last_nxt_s = 1'b0;
                out_iq_nxt_s    = 2'b00;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            byte_r      <= 8'h00;
            byte_full_r <= 1'b0;
            byte_last_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_iq_r    <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            byte_r      <= byte_nxt_s;
            byte_full_r <= byte_full_nxt_s;
            byte_last_r <= byte_last_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_iq_r    <= out_iq_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_I     = out_iq_r[1];
    assign out_Q     = out_iq_r[0];
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_tx_symbol_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_symbol_framer
// Randomised and directed stimulus for tx_symbol_framer (PREAMBLE_LEN=4,
// SYNC_WORD=16'hD391). Expected symbol streams are built per packet from the
// framing rules; CRC-8 uses polynomial long division of the augmented message.
// Define TX_FRAMER_CRC_EN for both DUT and bench to cover the CRC build.
// -----------------------------------------------------------------------------
module tb_tx_symbol_framer;

    localparam int          PL        = 4;
    localparam int          SB        = 16;
    localparam logic [15:0] SW        = 16'hD391;
    localparam int          STALL_IDX = PL + SB/2 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_I;
    logic       out_Q;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int         len_q[$];
    logic [7:0] pkt_q[$];
    int         sym_idx     = 0;
    int         rdy_cycles  = 0;
    int         bubbles     = 0;
    int         stall_left  = 3;
    bit         stall_test  = 1'b0;
    bit         rand_ready  = 1'b0;
    bit         end_chk     = 1'b0;
    bit         prev_stall  = 1'b0;
    logic [1:0] prev_iq     = 2'b00;

    tx_symbol_framer #(
        .PREAMBLE_LEN (PL),
        .SYNC_BITS    (SB),
        .SYNC_WORD    (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_I     (out_I),
        .out_Q     (out_Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc();
        logic [8:0] r;
        r = 9'h000;
        for (int i = 0; i < pkt_q.size() + 1; i++) begin
            logic [7:0] b;
            b = (i < pkt_q.size()) ? pkt_q[i] : 8'h00;
            for (int k = 7; k >= 0; k--) begin
                r = {r[7:0], b[k]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
    endfunction

    task automatic push_expected();
        logic [15:0] sw;
        int          n;
        sw = SW;
        n  = 0;
        for (int k = 0; k < PL; k++) begin
            exp_q.push_back((k % 2 == 0) ? 2'b11 : 2'b00);
            n++;
        end
        for (int j = 0; j < SB/2; j++) begin
            exp_q.push_back({sw[SB-1-2*j], sw[SB-2-2*j]});
            n++;
        end
        for (int i = 0; i < pkt_q.size(); i++) begin
            for (int s = 0; s < 4; s++) begin
                exp_q.push_back(2'((pkt_q[i] >> (6 - 2*s)) & 8'h03));
                n++;
            end
        end
`ifdef TX_FRAMER_CRC_EN
        begin
            logic [7:0] c;
            c = ref_crc();
            for (int s = 0; s < 4; s++) begin
                exp_q.push_back(2'((c >> (6 - 2*s)) & 8'h03));
                n++;
            end
        end
`endif
        len_q.push_back(n);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("byte_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gap_mode, input int fixed_gap);
        push_expected();
        for (int i = 0; i < pkt_q.size(); i++) begin
            logic lst;
            lst = (i == pkt_q.size() - 1);
            if (i > 0 && fixed_gap > 0) begin
                in_valid = 1'b0;
                repeat (fixed_gap) @(posedge clk);
                #1;
            end else if (gap_mode) begin
                int g;
                g = $urandom_range(0, 3);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            if (i == 0 && !busy && !out_valid) begin
                in_valid = 1'b1;
                in_data  = pkt_q[0];
                in_last  = lst;
                @(posedge clk); #1;
                check_eq("start_latency_valid", 32'(out_valid), 32'd1);
                check_eq("start_latency_iq", 32'({out_I, out_Q}), 32'd3);
            end
            push_byte(pkt_q[i], lst);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: steady, random, or a one-off 3-cycle stall.
    always @(posedge clk) begin
        #1;
        if (stall_test && out_valid && sym_idx == STALL_IDX && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sym_idx    = 0;
            end_chk    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (end_chk) begin
                check_eq("frame_gap_valid", 32'(out_valid), 32'd0);
                check_eq("frame_gap_busy", 32'(busy), 32'd0);
                end_chk = 1'b0;
            end
            if (prev_stall) begin
                check_eq("stall_hold_valid", 32'(out_valid), 32'd1);
                check_eq("stall_hold_iq", 32'({out_I, out_Q}), 32'(prev_iq));
            end
            if (!busy) check_eq("idle_in_ready", 32'(in_ready), 32'd0);
            if (in_ready && busy) rdy_cycles++;
            if (busy && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_symbol", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check_eq("symbol", 32'({out_I, out_Q}), 32'(e));
                end
                sym_idx++;
                if (len_q.size() > 0 && sym_idx == len_q[0]) begin
                    void'(len_q.pop_front());
                    sym_idx = 0;
                    end_chk = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_iq    = {out_I, out_Q};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int b0;
        bit reached;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_iq", 32'({out_I, out_Q}), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single-byte packet.
        pkt_q = '{8'hB4};
        send_frame(1'b0, 0);
        drain();

        // Two bytes, in_valid held high: no payload gap, two in_ready pulses.
        r0 = rdy_cycles;
        b0 = bubbles;
        pkt_q = '{8'hFF, 8'h00};
        send_frame(1'b0, 0);
        drain();
        check_eq("two_byte_in_ready_pulses", 32'(rdy_cycles - r0), 32'd2);
        check_eq("two_byte_bubbles", 32'(bubbles - b0), 32'd1);

        // Downstream stall on the second payload symbol.
        stall_test = 1'b1;
        pkt_q = '{8'hB4};
        send_frame(1'b0, 0);
        drain();
        stall_test = 1'b0;
        check_eq("stall_applied", 32'(stall_left), 32'd0);

        // Upstream gap of 5 cycles between bytes.
        pkt_q = '{8'h3C, 8'hA5};
        send_frame(1'b0, 5);
        drain();

        // Reset during SYNC, then a fresh frame.
        pkt_q = '{8'h77};
        push_expected();
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        reached  = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (sym_idx >= PL + 2) begin
                reached = 1'b1;
                break;
            end
        end
        check_eq("reached_sync", 32'(reached), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        len_q.delete();
        @(posedge clk); #1;
        check_eq("midframe_rst_valid", 32'(out_valid), 32'd0);
        check_eq("midframe_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        pkt_q = '{8'h5A};
        send_frame(1'b0, 0);
        drain();

        // Random packets, random gaps, random downstream back-pressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            int n;
            n = $urandom_range(1, 6);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            send_frame(1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        rand_ready = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_symbol_framer.md
Name: tx_symbol_framer

Overview:
- Upstream neighbour of the TX path top: turns an AXI-Stream byte stream into the per-cycle I/Q bit-pair stream the TX path consumes on in_I/in_Q/in_valid/in_ready.
- Wraps each packet (in_last-delimited) as: preamble, then sync word, then payload.
- Replaces ad-hoc byte-to-dibit glue with a proper valid/ready, frame-aware serializer.

Parameters:
- PREAMBLE_LEN, 16, number of preamble symbols (>=2, even).
- SYNC_WORD, 16'hD391, sync pattern, sent MSB first, 2 bits per symbol.
- SYNC_BITS, 16, width of SYNC_WORD (even, <=32).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  payload byte (AXIS tdata).
- in_valid  in  1  byte valid.
- in_last  in  1  last byte of packet.
- in_ready  out  1  byte accepted when in_valid&in_ready.
- out_I  out  1  symbol I bit.
- out_Q  out  1  symbol Q bit.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; out_valid=0, out_I=0, out_Q=0, in_ready=0, busy=0; byte register, symbol counters and CRC cleared. Reset mid-frame drops the frame silently and returns to IDLE.
- Output handshake: out_I/out_Q/out_valid are registered. While out_valid=1 and out_ready=0, all three are held stable. A symbol advances only on out_valid&out_ready.
- FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, CRC (CRC only with the optional feature).
- IDLE -> PREAMBLE: taken when in_valid=1. The byte is not consumed. The first preamble symbol is presented with out_valid=1 on the next cycle (latency 1).
- PREAMBLE: symbol k (k=0..PREAMBLE_LEN-1) has I=Q=~k[0], giving 11,00,11,00,… After the last preamble symbol is accepted -> SYNC.
- SYNC: SYNC_BITS/2 symbols. Symbol j carries I=SYNC_WORD[SYNC_BITS-1-2j], Q=the next lower bit. After the last sync symbol is accepted -> PAYLOAD.
- PAYLOAD: each byte gives 4 symbols, (b7,b6), (b5,b4), (b3,b2), (b1,b0).
  - in_ready=1 in PAYLOAD when the byte register is empty, or when its 4th symbol is being accepted this cycle. This gives zero-bubble throughput of 1 byte per 4 accepted symbols.
  - If in_valid=0 when a new byte is needed, out_valid drops to 0 (bubble; no filler symbols) until a byte arrives.
  - The in_last of the held byte is latched. After that byte's 4th symbol is accepted -> CRC if enabled, else IDLE.
- in_ready is 0 in IDLE, PREAMBLE, SYNC and CRC.
- Back-to-back packets: after returning to IDLE, a pending in_valid starts a new frame with a full preamble. There is at least one cycle with out_valid=0 between frames.
- in_last on a packet's first byte is legal (1-byte payload).

Optional Feature:
- Macro: TX_FRAMER_CRC_EN.
- Defined:
  - CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed MSB first over the payload bytes as each byte is accepted.
  - CRC state: 4 symbols, same bit order as payload, then IDLE.
  - CRC register cleared on entry to PREAMBLE.
- Undefined: no CRC state, no CRC logic; after the last payload symbol -> IDLE.

Decomposition:
- Package tx_framer_pkg holds:
  - state enum typedef (IDLE, PREAMBLE, SYNC, PAYLOAD, CRC);
  - dibit_t typedef (logic [1:0]);
  - CRC8_POLY=8'h07;
  - function crc8_byte(crc, byte).
- One natural sub-module: tx_crc8 (byte-wise CRC-8 update register with clear/enable), instantiated only under TX_FRAMER_CRC_EN.

Test Plan (PREAMBLE_LEN=4, SYNC_WORD=16'hD391, out_ready=1 unless stated):
- Single byte 0xB4 with in_last, no CRC -> symbols (IQ): 11,00,11,00, 11,01,00,11,10,01,00,01, 10,11,01,00; then out_valid=0 and busy=0.
- Same stimulus with TX_FRAMER_CRC_EN -> same 16 symbols followed by CRC 0x05: 00,00,01,01; then IDLE.
- Two-byte packet 0xFF, 0x00 (last), in_valid always high -> payload symbols 11,11,11,11,00,00,00,00 with no gap; in_ready pulses exactly twice.
- out_ready held low 3 cycles at payload symbol 2 of 0xB4 -> out_I/out_Q stay at 1/1 and out_valid stays 1 for those cycles; sequence resumes 01,00 with no loss or duplication.
- in_valid deasserted 5 cycles between bytes mid-packet -> out_valid=0 for the gap, no filler symbols; the next byte's symbols follow correctly.
- rst asserted during SYNC -> next cycle out_valid=0, busy=0, state IDLE; a new packet afterwards starts with the full 4-symbol preamble.
